// File: rtl/smart_mac_cfg_pe.sv
// smart_mac_cfg_pe: smart-bus MAC processing element with runtime configuration.
//
// All four operand directions can be bypassed onto the horizontal/vertical smart buses.
// The bypass selects and the accumulation length come from a config register. That register
// is loaded over a valid/ready handshake. Operand beats arrive on a valid/ready stream and are
// accumulated over a counted window. The finished sum is offered on a result port with
// backpressure.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data  config handshake
//                                 {acc_len, sel_left_in, sel_top_in, sel_right_out, sel_bottom_out}
//   in_valid/in_ready             operand beat handshake
//   left_in, top_in               neighbour operands
//   right_out, bottom_out         registered forwarded operands
//   fwd_valid                     forwarded operands updated this cycle
//   *_smart_bus_in/_out           horizontal/vertical smart buses
//   acc_out/acc_valid/acc_ready   completed accumulation result, held until consumed
module smart_mac_cfg_pe #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ACC_SIZE  = 32,
    parameter int unsigned CNT_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CNT_SIZE+3:0]   cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  left_in,
    input  logic [WORD_SIZE-1:0]  top_in,
    output logic [WORD_SIZE-1:0]  right_out,
    output logic [WORD_SIZE-1:0]  bottom_out,
    output logic                  fwd_valid,
    input  logic [WORD_SIZE-1:0]  horizontal_smart_bus_in,
    input  logic [WORD_SIZE-1:0]  vertical_smart_bus_in,
    output logic [WORD_SIZE-1:0]  horizontal_smart_bus_out,
    output logic [WORD_SIZE-1:0]  vertical_smart_bus_out,
    output logic [ACC_SIZE-1:0]   acc_out,
    output logic                  acc_valid,
    input  logic                  acc_ready
);

    typedef enum logic [1:0] {StIdle, StReady, StAcc} state_e;

    state_e                state_q, state_d;
    logic [CNT_SIZE+3:0]   cfg_q, cfg_d;
    logic [CNT_SIZE-1:0]   count_q, count_d;
    logic [ACC_SIZE-1:0]   acc_q, acc_d;
    logic [WORD_SIZE-1:0]  right_q, right_d;
    logic [WORD_SIZE-1:0]  bottom_q, bottom_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ACC_SIZE-1:0]   acc_out_q, acc_out_d;
    logic                  acc_valid_q, acc_valid_d;

    logic                        sel_left, sel_top, sel_right, sel_bottom;
    logic [CNT_SIZE-1:0]         acc_len, eff_len;
    logic signed [WORD_SIZE-1:0] op_l, op_t;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic [ACC_SIZE-1:0]         prod_ext, sum;
    logic                        is_last, cfg_fire, beat_fire;

    assign sel_left   = cfg_q[3];
    assign sel_top    = cfg_q[2];
    assign sel_right  = cfg_q[1];
    assign sel_bottom = cfg_q[0];
    assign acc_len    = cfg_q[CNT_SIZE+3:4];
    // A zero length behaves as a single-beat window.
    assign eff_len    = (acc_len == '0) ? CNT_SIZE'(1) : acc_len;
    assign is_last    = (count_q == eff_len - CNT_SIZE'(1));

    assign op_l = sel_left ? horizontal_smart_bus_in : left_in;
    assign op_t = sel_top  ? vertical_smart_bus_in   : top_in;

    // Signed casts sign-extend the operands before the full-width multiply.
    assign prod     = (2*WORD_SIZE)'(op_l) * (2*WORD_SIZE)'(op_t);
    assign prod_ext = ACC_SIZE'(prod);
    assign sum      = (count_q == '0) ? prod_ext : acc_q + prod_ext;

    assign horizontal_smart_bus_out = sel_right  ? right_q  : horizontal_smart_bus_in;
    assign vertical_smart_bus_out   = sel_bottom ? bottom_q : vertical_smart_bus_in;

    assign cfg_ready = (state_q != StAcc);
    // Only a last beat can be blocked, and only by an unconsumed result.
    assign in_ready  = (state_q != StIdle) && !(is_last && acc_valid_q && !acc_ready);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign beat_fire = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        count_d     = count_q;
        acc_d       = acc_q;
        right_d     = right_q;
        bottom_d    = bottom_q;
        fwd_valid_d = 1'b0;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;

        if (acc_valid_q && acc_ready) begin
            acc_valid_d = 1'b0;
        end

        if (cfg_fire) begin
            cfg_d = cfg_data;
        end

        if (beat_fire) begin
            right_d     = op_l;
            bottom_d    = op_t;
            fwd_valid_d = 1'b1;
            acc_d       = sum;
            if (is_last) begin
                acc_out_d   = sum;
                acc_valid_d = 1'b1;
                count_d     = '0;
            end else begin
                count_d = count_q + CNT_SIZE'(1);
            end
        end

        unique case (state_q)
            StIdle:  if (cfg_fire) state_d = StReady;
            StReady: if (beat_fire && !is_last) state_d = StAcc;
            StAcc:   if (beat_fire && is_last) state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cfg_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            right_q     <= '0;
            bottom_q    <= '0;
            fwd_valid_q <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            right_q     <= right_d;
            bottom_q    <= bottom_d;
            fwd_valid_q <= fwd_valid_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign right_out  = right_q;
    assign bottom_out = bottom_q;
    assign fwd_valid  = fwd_valid_q;
    assign acc_out    = acc_out_q;
    assign acc_valid  = acc_valid_q;

endmodule

// File: tb/tb_smart_mac_cfg_pe.sv
// Directed testbench for smart_mac_cfg_pe.
// Expected results go into a scoreboard queue when a last beat is driven. A monitor pops them
// when a result handshake completes.
module tb_smart_mac_cfg_pe;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned ACC_SIZE  = 32;
    localparam int unsigned CNT_SIZE  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [CNT_SIZE+3:0]  cfg_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] left_in = '0, top_in = '0;
    logic [WORD_SIZE-1:0] right_out, bottom_out;
    logic                 fwd_valid;
    logic [WORD_SIZE-1:0] hbus_in = '0, vbus_in = '0, hbus_out, vbus_out;
    logic [ACC_SIZE-1:0]  acc_out;
    logic                 acc_valid;
    logic                 acc_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [ACC_SIZE-1:0] exp_q[$];

    smart_mac_cfg_pe #(
        .WORD_SIZE(WORD_SIZE),
        .ACC_SIZE (ACC_SIZE),
        .CNT_SIZE (CNT_SIZE)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cfg_valid                (cfg_valid),
        .cfg_ready                (cfg_ready),
        .cfg_data                 (cfg_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .left_in                  (left_in),
        .top_in                   (top_in),
        .right_out                (right_out),
        .bottom_out               (bottom_out),
        .fwd_valid                (fwd_valid),
        .horizontal_smart_bus_in  (hbus_in),
        .vertical_smart_bus_in    (vbus_in),
        .horizontal_smart_bus_out (hbus_out),
        .vertical_smart_bus_out   (vbus_out),
        .acc_out                  (acc_out),
        .acc_valid                (acc_valid),
        .acc_ready                (acc_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees the handshake.
    always @(negedge clk) begin
        if (rst && acc_valid && acc_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed result %0h expected none pending", acc_out);
            end
            if (exp_q.size() != 0) begin
                logic [ACC_SIZE-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (acc_out === e) else begin
                    errors++;
                    $error("FAIL sb_result: observed %0h expected %0h", acc_out, e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 once the config is accepted.
    task automatic do_cfg(input logic [CNT_SIZE-1:0] len, input logic [3:0] sel);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_data  = {len, sel};
        while (!cfg_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("cfg_timeout", {63'd0, cfg_ready}, 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Drives one beat, optionally pushing its expected result, and checks the forwarded operands.
    // Leaves in_valid high; the caller drops it or drives the next beat.
    task automatic beat(input logic [WORD_SIZE-1:0] l, input logic [WORD_SIZE-1:0] t,
                        input logic [WORD_SIZE-1:0] exp_r, input logic [WORD_SIZE-1:0] exp_b,
                        input bit push, input logic [ACC_SIZE-1:0] exp_acc);
        int n = 0;
        in_valid = 1'b1;
        left_in  = l;
        top_in   = t;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("beat_timeout", {63'd0, in_ready}, 64'd1);
        if (push) exp_q.push_back(exp_acc);
        @(posedge clk); #1;
        check("right_out", 64'(right_out), 64'(exp_r));
        check("bottom_out", 64'(bottom_out), 64'(exp_b));
        check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
    endtask

    initial begin
        // Reset and unconfigured behaviour.
        #12;
        check("rst_acc_valid", {63'd0, acc_valid}, 64'd0);
        check("rst_acc_out", 64'(acc_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        left_in  = 16'd5;
        top_in   = 16'd5;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd0);
        check("idle_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("idle_acc_valid", {63'd0, acc_valid}, 64'd0);
        check("idle_right_out", 64'(right_out), 64'd0);
        check("idle_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        in_valid = 1'b0;

        // Three-beat window: 6 - 20 + 7 = -7.
        do_cfg(8'd3, 4'b0000);
        beat(16'd2, 16'd3, 16'd2, 16'd3, 1'b0, '0);
        check("win3_mid_valid", {63'd0, acc_valid}, 64'd0);
        beat(-16'sd4, 16'd5, -16'sd4, 16'd5, 1'b0, '0);
        beat(16'd7, 16'd1, 16'd7, 16'd1, 1'b1, -32'sd7);
        in_valid = 1'b0;
        check("win3_acc_valid", {63'd0, acc_valid}, 64'd1);
        check("win3_acc_out", 64'(acc_out), 64'(32'hFFFF_FFF9));
        @(posedge clk); #1;
        check("fwd_valid_drop", {63'd0, fwd_valid}, 64'd0);
        check("win3_result_taken", {63'd0, acc_valid}, 64'd0);

        // Result-port backpressure on back-to-back single-beat windows.
        do_cfg(8'd1, 4'b0000);
        acc_ready = 1'b0;
        beat(16'd3, 16'd3, 16'd3, 16'd3, 1'b1, 32'd9);
        left_in = 16'd2;
        top_in  = 16'd2;
        #1;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("bp_acc_held", 64'(acc_out), 64'd9);
        check("bp_valid_held", {63'd0, acc_valid}, 64'd1);
        check("bp_in_ready_still", {63'd0, in_ready}, 64'd0);
        check("bp_right_held", 64'(right_out), 64'd3);
        acc_ready = 1'b1;
        exp_q.push_back(32'd4);
        #1;
        check("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_reload_valid", {63'd0, acc_valid}, 64'd1);
        check("bp_reload_out", 64'(acc_out), 64'd4);
        @(posedge clk); #1;

        // Left operand taken from the horizontal bus.
        do_cfg(8'd1, 4'b1000);
        hbus_in = 16'd10;
        beat(16'd99, 16'd2, 16'd10, 16'd2, 1'b1, 32'd20);
        in_valid = 1'b0;
        check("sel_left_acc", 64'(acc_out), 64'd20);
        check("hbus_passthru", 64'(hbus_out), 64'd10);

        // Vertical bus pass-through, then switched onto bottom_out after config.
        vbus_in = 16'h1234;
        do_cfg(8'd1, 4'b0000);
        check("vbus_passthru", 64'(vbus_out), 64'h1234);
        cfg_valid = 1'b1;
        cfg_data  = {8'd1, 4'b0001};
        #1;
        check("vbus_before_edge", 64'(vbus_out), 64'h1234);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("vbus_bottom_sel", 64'(vbus_out), 64'd2);

        // Relay configuration: bus outputs hold the forwarded registers with no beats.
        do_cfg(8'd1, 4'b1111);
        check("relay_hbus", 64'(hbus_out), 64'd10);
        check("relay_vbus", 64'(vbus_out), 64'd2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("relay_hbus_hold", 64'(hbus_out), 64'd10);

        // acc_len = 0 acts as a single-beat window.
        do_cfg(8'd0, 4'b0000);
        beat(-16'sd3, 16'd4, -16'sd3, 16'd4, 1'b1, -32'sd12);
        in_valid = 1'b0;
        check("len0_valid", {63'd0, acc_valid}, 64'd1);
        check("len0_out", 64'(acc_out), 64'(32'hFFFF_FFF4));
        @(posedge clk); #1;

        // Largest positive products: 2 * 0x3FFF0001.
        do_cfg(8'd2, 4'b0000);
        beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, '0);
        beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 32'h7FFE_0002);
        in_valid = 1'b0;
        check("max_acc_out", 64'(acc_out), 64'h7FFE_0002);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a window.
        beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0, '0);
        in_valid = 1'b0;
        hbus_in  = 16'h0055;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_acc_out", 64'(acc_out), 64'd0);
        check("mid_rst_acc_valid", {63'd0, acc_valid}, 64'd0);
        check("mid_rst_right", 64'(right_out), 64'd0);
        check("mid_rst_bottom", 64'(bottom_out), 64'd0);
        check("mid_rst_fwd", {63'd0, fwd_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        check("mid_rst_hbus", 64'(hbus_out), 64'h0055);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;

        // After reconfiguring, the discarded partial sum must not leak into the result.
        do_cfg(8'd1, 4'b0000);
        beat(16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 32'd25);
        in_valid = 1'b0;
        check("post_rst_acc", 64'(acc_out), 64'd25);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smart_mac_cfg_pe.md
Name: smart_mac_cfg_pe

Overview:
- Second-generation smart-bus MAC processing element for the systolic array.
- Generalises the single-bypass smart MAC: all four directions are independently bypassable onto the horizontal/vertical smart buses.
- Bypass selects and accumulation length come from a runtime config register loaded over a valid/ready handshake, not from static pins.
- Adds a valid/ready operand stream, a counted accumulation window and a result port with backpressure.

Parameters:
WORD_SIZE, 16, operand and bus word width (signed two's complement)
ACC_SIZE, 32, accumulator/result width; must be >= 2*WORD_SIZE
CNT_SIZE, 8, width of accumulation-length field and beat counter

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  config word offered
cfg_ready  out  1  config word acceptable this cycle
cfg_data  in  CNT_SIZE+4  [3]=sel_left_in_smart [2]=sel_top_in_smart [1]=sel_right_out_smart [0]=sel_bottom_out_smart [CNT_SIZE+3:4]=acc_len
in_valid  in  1  operand beat valid
in_ready  out  1  PE accepts operand beat
left_in, top_in  in  WORD_SIZE  neighbour operands
right_out, bottom_out  out  WORD_SIZE  registered forwarded operands
fwd_valid  out  1  right_out/bottom_out updated this cycle
horizontal_smart_bus_in, vertical_smart_bus_in  in  WORD_SIZE  smart bus inputs
horizontal_smart_bus_out, vertical_smart_bus_out  out  WORD_SIZE  smart bus outputs
acc_out  out  ACC_SIZE  completed accumulation result
acc_valid  out  1  acc_out valid; held until acc_ready
acc_ready  in  1  downstream consumes result

Behaviour:
- Reset (rst=0, async): state=IDLE; config register=0; count=0; acc=0; right_out=bottom_out=0; fwd_valid=0; acc_out=0; acc_valid=0.
- Operand muxes (comb): L = sel_left_in_smart ? horizontal_smart_bus_in : left_in; T = sel_top_in_smart ? vertical_smart_bus_in : top_in.
- Bus muxes (comb): horizontal_smart_bus_out = sel_right_out_smart ? right_out : horizontal_smart_bus_in; vertical_smart_bus_out = sel_bottom_out_smart ? bottom_out : vertical_smart_bus_in.
- FSM states:
  - IDLE: unconfigured; in_ready=0; cfg_ready=1. Config handshake -> READY.
  - READY: configured, count=0; cfg_ready=1, in_ready=1. Beat -> ACC, or stays READY when acc_len<=1.
  - ACC: count>0; cfg_ready=0. The last beat returns to READY.
- Config handshake (cfg_valid&cfg_ready) loads the register at the clock edge; the new selects take effect the following cycle.
- Beat accepted when in_valid&in_ready. At that edge:
  - right_out<=L, bottom_out<=T, fwd_valid<=1 (otherwise fwd_valid<=0; outputs hold).
  - P = sign-extended L*T (2*WORD_SIZE product, sign-extended to ACC_SIZE).
  - If count==0: acc<=P, else acc<=acc+P. Wraps modulo 2^ACC_SIZE; no saturation.
- Last beat = count==eff_len-1, where eff_len = max(acc_len,1); acc_len=0 behaves as 1.
  - On the last beat: acc_out<=(count==0 ? P : acc+P), acc_valid<=1, count<=0.
  - Otherwise count<=count+1.
- Latency: result visible the cycle after the last beat. Forwarded operands visible 1 cycle after acceptance.
- acc_valid clears on acc_valid&acc_ready unless a new last beat is accepted in the same cycle; in that case acc_out reloads and acc_valid stays 1.
- Backpressure: in_ready=0 when the next beat would be a last beat and acc_valid&~acc_ready. Non-last beats are never stalled by the result port.
- Bypass-only use: a pure relay PE is configured with all four selects set and accumulates nothing meaningful; the bus outputs stay valid without in_valid.
- Reset mid-accumulation discards the partial sum and the config. The PE must be reconfigured before accepting beats.

Test Plan:
- Reset then in_valid=1 with no cfg -> in_ready=0, acc_valid stays 0, right_out=0.
- Cfg acc_len=3, selects=0; beats (2,3),(-4,5),(7,1) -> one cycle after 3rd beat acc_out=-7, acc_valid=1; right_out/bottom_out track 2,-4,7 / 3,5,1 with 1-cycle lag.
- acc_len=1, acc_ready=0, two back-to-back beats (3,3),(2,2) -> acc_out=9 held; in_ready=0 on 2nd beat until acc_ready=1, then acc_out=4.
- sel_left_in_smart=1, horizontal_smart_bus_in=10, left_in=99, top_in=2, acc_len=1 -> acc_out=20, right_out=10.
- sel_bottom_out_smart=0, vertical_smart_bus_in=0x1234 -> vertical_smart_bus_out=0x1234 same cycle; set select=1 -> equals bottom_out one cycle after config accept.
- WORD_SIZE=16, acc_len=2, beats (0x7FFF,0x7FFF) twice -> acc_out=0x7FFE0002; assert rst low mid-window -> all outputs 0 immediately, state IDLE.
